// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg: shared occupancy states and binary-to-one-hot decode helper
package onehot_dec_pkg;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e;
  localparam int MAX_OUT = 64;
  typedef struct packed {
    logic err;
    logic [MAX_OUT-1:0] oh;
  } dec_t;
  function automatic dec_t to_onehot(input logic [31:0] code, input int num_out);
    dec_t d;
    d.err = code >= $unsigned(num_out);
    d.oh = d.err ? '0 : MAX_OUT'(1) << code;
    return d;
  endfunction
endpackage

// File: rtl/onehot_dec_fifo2.sv
// onehot_dec_fifo2: two-entry fifo with empty/one/two occupancy fsm and zeroed output when empty
module onehot_dec_fifo2
  import onehot_dec_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  occ_e occ, occ_n;
  logic rd_ptr, wr_ptr, push, pop;
  logic [W-1:0] mem [2];
  assign in_ready  = occ != OCC_TWO;
  assign out_valid = occ != OCC_EMPTY;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  always_comb begin
    occ_n = occ;
    occ_n = occ == OCC_EMPTY ? (push ? OCC_ONE : OCC_EMPTY)
          : occ == OCC_ONE   ? (push && !pop ? OCC_TWO : pop && !push ? OCC_EMPTY : OCC_ONE)
          :                    (pop ? OCC_ONE : OCC_TWO);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= OCC_EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      occ <= occ_n;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
endmodule

// File: rtl/onehot_decoder_stream.sv
// onehot_decoder_stream: streaming binary-to-one-hot decoder behind a 2-entry buffer; DEC_PARITY_EN adds in_parity even-parity check
module onehot_decoder_stream
  import onehot_dec_pkg::*;
#(
  parameter int CODE_W  = 2,
  parameter int NUM_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CODE_W-1:0]  in_code,
`ifdef DEC_PARITY_EN
  input  logic               in_parity,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic               out_err
);
  dec_t d;
  logic bad;
  logic [NUM_OUT-1:0] oh;
  assign d = to_onehot(32'(in_code), NUM_OUT);
`ifdef DEC_PARITY_EN
  assign bad = d.err | (|d.oh[MAX_OUT-1:NUM_OUT]) | (^{in_code, in_parity});
`else
  assign bad = d.err | (|d.oh[MAX_OUT-1:NUM_OUT]);
`endif
  assign oh = bad ? '0 : d.oh[NUM_OUT-1:0];
  onehot_dec_fifo2 #(.W(NUM_OUT + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({bad, oh}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_err, out_onehot})
  );
endmodule
